// File: rtl/product_accumulator.sv
// Accumulates N_SAMPLES valid products from the upstream multiplier into a saturating sum,
// flags illegal products, and reports the result through a start/done/ack handshake.
`timescale 1ns/1ps
module product_accumulator #(
  parameter int N_SAMPLES = 4,
  parameter int SUM_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       y_in,
  input  logic             y_valid,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] sum,
  output logic             err,
  output logic             ovf,
  output logic [3:0]       last_y
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ACCUM = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  localparam logic [7:0] LP_N = 8'(N_SAMPLES);

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_cnt;
  logic [SUM_W-1:0] r_sum;
  logic             r_err;
  logic             r_ovf;
  logic [3:0]       r_last_y;

  logic             w_start_run;
  logic             w_accept;
  logic             w_last_sample;
  logic             w_legal;
  logic             w_carry;
  logic [SUM_W-1:0] w_add;

  // start is honoured from every legal state and beats a coincident sample
  assign w_start_run   = start && (r_state inside {S_IDLE, S_ACCUM, S_DONE});
  assign w_accept      = (r_state == S_ACCUM) && y_valid && !start;
  assign w_last_sample = (r_cnt + 8'd1) == LP_N;
  assign w_legal       = y_in inside {4'd0, 4'd3, 4'd6, 4'd9};
  assign {w_carry, w_add} = {1'b0, r_sum} + (SUM_W+1)'(y_in);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: give every combinational output a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ACCUM;
      S_ACCUM: begin
        if (start)                          w_next = S_ACCUM;
        else if (y_valid && w_last_sample)  w_next = S_DONE;
      end
      S_DONE: begin
        if (start)    w_next = S_ACCUM;
        else if (ack) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_ACCUM: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // NOTE: all datapath registers are reset asynchronously so a mid-run reset
  // discards the partial result immediately, without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_sum    <= '0;
      r_err    <= 1'b0;
      r_ovf    <= 1'b0;
      r_last_y <= '0;
    end else if (w_start_run) begin
      r_cnt <= '0;
      r_sum <= '0;
      r_err <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= r_cnt + 8'd1;
      r_last_y <= y_in;
      r_sum    <= w_carry ? '1 : w_add;
      r_ovf    <= r_ovf | w_carry;
      r_err    <= r_err | !w_legal;
    end
  end

  assign sum    = r_sum;
  assign err    = r_err;
  assign ovf    = r_ovf;
  assign last_y = r_last_y;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed plus random stimulus for two product_accumulator instances (4 and 32 samples),
// compared against a sum-of-samples reference model.
`timescale 1ns/1ps
module tb_product_accumulator;

  localparam int SUM_W = 8;
  localparam int N_A   = 4;
  localparam int N_B   = 32;
  localparam int MAXV  = (1 << SUM_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic y_valid = 1'b0;
  logic ack = 1'b0;
  logic [3:0] y_in = '0;

  logic busy_a, done_a, err_a, ovf_a;
  logic busy_b, done_b, err_b, ovf_b;
  logic [SUM_W-1:0] sum_a, sum_b;
  logic [3:0] last_y_a, last_y_b;

  product_accumulator #(.N_SAMPLES(N_A), .SUM_W(SUM_W)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .y_in(y_in), .y_valid(y_valid), .ack(ack),
    .busy(busy_a), .done(done_a), .sum(sum_a), .err(err_a), .ovf(ovf_a), .last_y(last_y_a)
  );

  product_accumulator #(.N_SAMPLES(N_B), .SUM_W(SUM_W)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .y_in(y_in), .y_valid(y_valid), .ack(ack),
    .busy(busy_b), .done(done_b), .sum(sum_b), .err(err_b), .ovf(ovf_b), .last_y(last_y_b)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference: unbounded running total of the run's samples; saturation is its clip.
  int   n_cfg   [2] = '{N_A, N_B};
  int   m_total [2];
  int   m_cnt   [2];
  bit   m_err   [2];
  bit   m_busy  [2];
  bit   m_done  [2];
  int   m_last  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_total[i] = 0; m_cnt[i] = 0; m_err[i] = 0;
      m_busy[i]  = 0; m_done[i] = 0; m_last[i] = 0;
    end
  endfunction

  function automatic void model_edge(input bit s, input bit v, input int y, input bit a);
    for (int i = 0; i < 2; i++) begin
      if (s) begin
        m_total[i] = 0; m_cnt[i] = 0; m_err[i] = 0;
        m_busy[i]  = 1; m_done[i] = 0;
      end else if (m_busy[i] && v) begin
        m_total[i] += y;
        m_cnt[i]++;
        m_last[i] = y;
        if ((y % 3) != 0 || y > 9) m_err[i] = 1;
        if (m_cnt[i] == n_cfg[i]) begin
          m_busy[i] = 0;
          m_done[i] = 1;
        end
      end else if (m_done[i] && a) begin
        m_done[i] = 0;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    int exp_sum [2];
    for (int i = 0; i < 2; i++) exp_sum[i] = (m_total[i] > MAXV) ? MAXV : m_total[i];
    chk({tag, " a.busy"},   busy_a,   m_busy[0]);
    chk({tag, " a.done"},   done_a,   m_done[0]);
    chk({tag, " a.sum"},    sum_a,    exp_sum[0]);
    chk({tag, " a.err"},    err_a,    m_err[0]);
    chk({tag, " a.ovf"},    ovf_a,    m_total[0] > MAXV);
    chk({tag, " a.last_y"}, last_y_a, m_last[0]);
    chk({tag, " b.busy"},   busy_b,   m_busy[1]);
    chk({tag, " b.done"},   done_b,   m_done[1]);
    chk({tag, " b.sum"},    sum_b,    exp_sum[1]);
    chk({tag, " b.err"},    err_b,    m_err[1]);
    chk({tag, " b.ovf"},    ovf_b,    m_total[1] > MAXV);
    chk({tag, " b.last_y"}, last_y_b, m_last[1]);
  endtask

  // Drives one cycle of inputs, lets one rising edge pass, then checks 1 ns later.
  task automatic step(input string tag, input bit s, input bit v, input int y, input bit a);
    start = s; y_valid = v; y_in = 4'(y); ack = a;
    @(posedge clk);
    model_edge(s, v, y, a);
    #1;
    check_all(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seq1 [4] = '{0, 3, 6, 9};
    int seq2 [4] = '{5, 6, 9, 0};

    // Reset state
    model_reset();
    #2 check_all("reset");
    #10 rst_n = 1'b1;

    // Legal sequence 0,3,6,9 -> sum 18, then ack
    step("t1.start", 1, 0, 0, 0);
    foreach (seq1[i]) step($sformatf("t1.s%0d", i), 0, 1, seq1[i], 0);
    chk("t1.sum18", sum_a, 18);
    step("t1.ack", 0, 0, 0, 1);

    // Gaps and an illegal sample
    step("t2.start", 1, 0, 0, 0);
    step("t2.s0", 0, 1, 3, 0);
    for (int i = 0; i < 3; i++) step("t2.gap", 0, 0, 9, 0);
    for (int i = 0; i < 3; i++) step($sformatf("t2.s%0d", i + 1), 0, 1, seq2[i], 0);
    chk("t2.sum23", sum_a, 23);

    // Saturation on the 32-sample instance
    step("t3.start", 1, 0, 0, 0);
    for (int i = 0; i < N_B; i++) step($sformatf("t3.s%0d", i), 0, 1, 9, 0);
    chk("t3.sat", sum_b, MAXV);
    chk("t3.done", done_b, 1);

    // Asynchronous mid-run reset
    step("t4.start", 1, 0, 0, 0);
    step("t4.s0", 0, 1, 6, 0);
    step("t4.s1", 0, 1, 6, 0);
    y_valid = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("t4.async_rst");
    #1 rst_n = 1'b1;
    step("t4.restart", 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("t4.s3", 0, 1, 3, 0);
    chk("t4.sum12", sum_a, 12);

    // start beats a coincident sample
    step("t5.start", 1, 0, 0, 0);
    step("t5.s0", 0, 1, 9, 0);
    step("t5.s1", 0, 1, 9, 0);
    step("t5.restart", 1, 1, 6, 0);
    chk("t5.cleared", sum_a, 0);
    for (int i = 0; i < 4; i++) step("t5.s3", 0, 1, 3, 0);
    chk("t5.sum12", sum_a, 12);

    // y_valid ignored in DONE and IDLE; start+ack in DONE restarts
    step("t6.done_v", 0, 1, 9, 0);
    step("t6.done_v", 0, 1, 9, 0);
    step("t6.ack", 0, 0, 0, 1);
    step("t6.idle_v", 0, 1, 9, 0);
    step("t6.idle_v", 0, 0, 9, 0);
    step("t6.start", 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("t6.s", 0, 1, 6, 0);
    step("t6.start_ack", 1, 0, 0, 1);
    chk("t6.busy", busy_a, 1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      bit s, v, a;
      int y;
      s = ($urandom_range(0, 24) == 0);
      v = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 5) == 0);
      y = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : 3 * int'($urandom_range(0, 3));
      step("rand", s, v, y, a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
